mem_fwd_history: RTL

// - Parametrised successor of the single-entry lw->sw store-data forwarder in the MEM stage.
// - Compares the rt of the store in EX/MEM against the write in MEM/WB this cycle (age 0).
// - Also keeps a DEPTH-entry history of recent writebacks (ages 1..DEPTH).
// - The history closes the hazard where the store read its rt in ID before the older write reached the RF.
// - Drives forward_m/forward_data into the MEM-stage store-data mux.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_prio_sel.sv | 34 +++
 rtl/mem_fwd_history.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the MEM-stage store-data forwarder.
package fwd_pkg;

  localparam int FWD_DATA_W = 32;
  localparam int FWD_REG_AW = 5;
  localparam int REG_ZERO   = 0;

  // One recorded writeback at the default pipeline widths.
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic [FWD_DATA_W-1:0] data;
  } fwd_entry_t;

  function automatic int ageWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Youngest-match selector over DEPTH+1 writeback sources (index 0 = youngest).
module fwd_prio_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int AGE_W  = 2
) (
  input  logic                         keyValid,
  input  logic [REG_AW-1:0]            key,
  input  logic [DEPTH:0]               srcValid,
  input  logic [DEPTH:0][REG_AW-1:0]   srcRd,
  input  logic [DEPTH:0][DATA_W-1:0]   srcData,
  output logic                         hit,
  output logic [DATA_W-1:0]            data,
  output logic [AGE_W-1:0]             age
);

  logic match_s;

  // Scan oldest to youngest so the youngest matching source is the last one kept.
  always_comb begin
    hit     = 1'b0;
    data    = {DATA_W{1'b0}};
    age     = {AGE_W{1'b0}};
    match_s = 1'b0;
    for (int i = DEPTH; i >= 0; i--) begin
      match_s = keyValid && srcValid[i] && (srcRd[i] == key);
      hit     = hit | match_s;
      data    = match_s ? srcData[i] : data;
      age     = match_s ? AGE_W'(i) : age;
    end
  end

endmodule

// File: rtl/mem_fwd_history.sv
// MEM-stage store-data forwarder with a DEPTH-entry writeback history.
// Optional MEM_FWD_STATS_EN adds a saturating fwd_count output.
module mem_fwd_history
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOADS_ONLY = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          memwb_reg_write,
  input  logic                          memwb_mem_to_reg,
  input  logic [REG_AW-1:0]             memwb_rd,
  input  logic [DATA_W-1:0]             memwb_data,
  input  logic                          exmem_mem_write,
  input  logic [REG_AW-1:0]             exmem_rt,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          forward_m,
  output logic [DATA_W-1:0]             forward_data,
  output logic [ageWidth(DEPTH)-1:0]    hit_age
`ifdef MEM_FWD_STATS_EN
  ,
  output logic [31:0]                   fwd_count
`endif
);

  localparam int AGE_W = ageWidth(DEPTH);

  logic                          qualWrite_s;
  logic                          keyValid_s;
  logic [DEPTH:1]                histValid_r;
  logic [DEPTH:1][REG_AW-1:0]    histRd_r;
  logic [DEPTH:1][DATA_W-1:0]    histData_r;
  logic [DEPTH:0]                srcValid_s;
  logic [DEPTH:0][REG_AW-1:0]    srcRd_s;
  logic [DEPTH:0][DATA_W-1:0]    srcData_s;
  logic                          selHit_s;
  logic [DATA_W-1:0]             selData_s;
  logic [AGE_W-1:0]              selAge_s;

  // Qualify the WB write and the store lookup key; $zero never takes part.
  always_comb begin
    qualWrite_s = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) &&
                  (memwb_mem_to_reg || (LOADS_ONLY == 0));
    keyValid_s  = exmem_mem_write && (exmem_rt != REG_AW'(REG_ZERO));
  end

  // Source 0 is the live WB write, sources 1..DEPTH are the recorded history.
  always_comb begin
    srcValid_s    = {(DEPTH+1){1'b0}};
    srcRd_s       = '{default: {REG_AW{1'b0}}};
    srcData_s     = '{default: {DATA_W{1'b0}}};
    srcValid_s[0] = qualWrite_s;
    srcRd_s[0]    = memwb_rd;
    srcData_s[0]  = memwb_data;
    for (int k = 1; k <= DEPTH; k++) begin
      srcValid_s[k] = histValid_r[k];
      srcRd_s[k]    = histRd_r[k];
      srcData_s[k]  = histData_r[k];
    end
  end

  // History shift register: flush beats stall, stall beats shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      histValid_r <= {DEPTH{1'b0}};
    end else if (flush) begin
      histValid_r <= {DEPTH{1'b0}};
    end else if (stall) begin
      histValid_r <= histValid_r;
    end else begin
      histValid_r[1] <= qualWrite_s;
      histRd_r[1]    <= memwb_rd;
      histData_r[1]  <= memwb_data;
      for (int k = 2; k <= DEPTH; k++) begin
        histValid_r[k] <= histValid_r[k-1];
        histRd_r[k]    <= histRd_r[k-1];
        histData_r[k]  <= histData_r[k-1];
      end
    end
  end

  fwd_prio_sel #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .AGE_W  (AGE_W)
  ) uPrioSel (
    .keyValid (keyValid_s),
    .key      (exmem_rt),
    .srcValid (srcValid_s),
    .srcRd    (srcRd_s),
    .srcData  (srcData_s),
    .hit      (selHit_s),
    .data     (selData_s),
    .age      (selAge_s)
  );

  // Outputs are forced quiet while reset is asserted, whatever the inputs do.
  always_comb begin
    if (!rst_n) begin
      forward_m    = 1'b0;
      forward_data = {DATA_W{1'b0}};
      hit_age      = {AGE_W{1'b0}};
    end else begin
      forward_m    = selHit_s;
      forward_data = selData_s;
      hit_age      = selAge_s;
    end
  end

`ifdef MEM_FWD_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  logic [31:0] fwdCount_r;

  // Saturating count of forwards taken on non-stalled cycles; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwdCount_r <= 32'd0;
    end else if (forward_m && !stall && (fwdCount_r != CNT_MAX)) begin
      fwdCount_r <= fwdCount_r + 32'd1;
    end else begin
      fwdCount_r <= fwdCount_r;
    end
  end

  assign fwd_count = fwdCount_r;
`endif

endmodule
